iterative_multiplier: RTL and testbench
=======================================

Name: iterative_multiplier

Overview:
Multi-cycle RV32M multiply unit that sits between the register file read ports and its write port. It consumes two operands read from the register file and computes one of MUL/MULH/MULHSU/MULHU with a shift-add datapath, one multiplier bit per cycle. It then issues a single-cycle write-back (wr_ena/wr_addr/wr_data) that connects directly to the register file write channel.

Parameters:
N, 32, operand width. Fixed by RV32M; the product is 2N bits wide internally.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  2  00 MUL (low N bits), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high); equals funct3[1:0]
rs1_data  input  N  multiplicand (register file rd_data0)
rs2_data  input  N  multiplier (register file rd_data1)
rd_addr  input  5  destination register
busy  output  1  high while an operation is in flight
wr_ena  output  1  write-back strobe to the register file
wr_addr  output  5  write-back address
wr_data  output  N  write-back data

Behaviour:
- Reset: state=IDLE; busy=0, wr_ena=0, wr_addr=0, wr_data=0; all internal registers cleared.
- Reset mid-operation: on the next edge the unit is back in IDLE with busy=0. No write is ever issued for the aborted operation.
- FSM states: IDLE, RUN, SIGN, DONE.
- IDLE: when start=1 at an edge, the unit latches op and rd_addr.
  - It latches the magnitudes |rs1| and |rs2| as N-bit unsigned values. An operand is treated as signed when op=01 (both operands), or op=10 (rs1 only), or op=00 (both). 0x80000000 has magnitude 0x80000000.
  - neg = sign(rs1) XOR sign(rs2), using the signed treatment above.
  - The unit clears the 2N-bit accumulator and the iteration counter, then goes to RUN.
- RUN, each cycle:
  - If multiplier[0]=1, acc += multiplicand (2N-bit, no overflow possible).
  - Multiplicand shifts left 1 (2N-bit); multiplier shifts right 1; counter increments.
  - After 32 iterations the FSM goes to SIGN.
- SIGN: if neg=1, acc = two's complement of acc (2N-bit). Go to DONE.
- DONE: wr_ena=1 for exactly this one cycle, unless the latched rd_addr=0, in which case wr_ena=0.
  - wr_addr = latched rd_addr.
  - wr_data = acc[N-1:0] when op=00, otherwise acc[2N-1:N].
  - Next state is IDLE.
- Outside DONE, wr_ena=0. wr_addr and wr_data hold their last value.
- busy: 0 in IDLE; 1 in RUN, SIGN and DONE.
- Latency: start sampled in cycle 0 → RUN in cycles 1–32, SIGN in cycle 33, DONE (wr_ena) in cycle 34. The earliest next start is accepted in cycle 35.
- start=1 while busy=1 is ignored and not queued. Operand inputs are don't-care except in the accept cycle.
- start asserted in the DONE cycle is ignored. start asserted in the following IDLE cycle is accepted.

Optional Feature:
Macro: MUL_EARLY_EXIT_EN.
- Defined: in RUN, if the remaining multiplier is 0, no add is performed and the next state is SIGN. The 32-iteration cap still applies.
  - With k = index of MSB of |rs2| + 1 (k=0 when rs2=0), DONE falls in cycle min(k+1, 32)+2.
  - Examples: rs2=0 → cycle 3; rs2=6 → cycle 6; MSB set → cycle 34.
  - Results are identical to the undefined case.
- Undefined: fixed 34-cycle latency for all operands.

Test Plan:
1. MUL, rs1=7, rs2=6, rd=5, start in cycle 0 → busy=1 in cycles 1–34; wr_ena=1 only in cycle 34 with wr_addr=5, wr_data=42; busy=0 in cycle 35.
2. MUL −3×5 → 0xFFFFFFF1. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. rd=0, MUL 9×9 → wr_ena stays 0 for the whole operation; busy still drops after cycle 34.
4. Second start pulse in cycle 5 with different operands → ignored; the single write in cycle 34 carries the first result. A start in cycle 35 is accepted.
5. rst=1 in cycle 10 of an operation → busy=0 from cycle 11; no wr_ena at any point. A new MUL 2×3 started afterwards writes 6 exactly 34 cycles after its start.
6. With MUL_EARLY_EXIT_EN defined:
   - MUL 5×0 → wr_ena in cycle 3, data 0.
   - MUL 5×6 → wr_ena in cycle 6, data 30.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → wr_ena in cycle 34, data 0xFFFFFFFE.

Source files
------------

// File: rtl/iterative_multiplier.sv
// Iterative RV32M multiplier: shift-add, one multiplier bit per cycle.
// Optional macro MUL_EARLY_EXIT_EN ends the add loop once the multiplier is zero.
module iterative_multiplier #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic [4:0]   rd_addr,
    output logic         busy,
    output logic         wr_ena,
    output logic [4:0]   wr_addr,
    output logic [N-1:0] wr_data
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    logic             neg_q, neg_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       wr_addr_q, wr_addr_d;
    logic [N-1:0]     wr_data_q, wr_data_d;

    logic             neg1, neg2;
    logic [N-1:0]     mag1, mag2;
    logic             step;
    logic             last;

    // Operand sign handling: MULHU is unsigned/unsigned, MULHSU signs rs1 only
    always_comb begin
        neg1 = (op != 2'b11) & rs1_data[N-1];
        neg2 = ~op[1] & rs2_data[N-1];
        mag1 = neg1 ? (~rs1_data + 1'b1) : rs1_data;
        mag2 = neg2 ? (~rs2_data + 1'b1) : rs2_data;
    end

`ifdef MUL_EARLY_EXIT_EN
    assign step = (mplier_q != '0);
`else
    assign step = 1'b1;
`endif
    assign last = (cnt_q == CW'(N - 1));

    // State register and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (!step || last) state_d = SIGN;
            SIGN: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand capture, shift-add, sign fix-up, result latch
    always_comb begin
        op_d      = op_q;
        rd_d      = rd_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    rd_d     = rd_addr;
                    neg_d    = neg1 ^ neg2;
                    acc_d    = '0;
                    mcand_d  = {{N{1'b0}}, mag1};
                    mplier_d = mag2;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                if (step) begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            SIGN: begin
                if (neg_q) acc_d = ~acc_q + 1'b1;
                wr_addr_d = rd_q;
                wr_data_d = (op_q == 2'b00) ? acc_d[N-1:0] : acc_d[2*N-1:N];
            end
            default: ;
        endcase
    end

    // Outputs: write strobe only in DONE and never to x0
    always_comb begin
        busy    = (state_q != IDLE);
        wr_ena  = (state_q == DONE) && (rd_q != 5'd0);
        wr_addr = wr_addr_q;
        wr_data = wr_data_q;
    end

endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed bench for iterative_multiplier.
// Expected latency follows MUL_EARLY_EXIT_EN when defined.
module tb_iterative_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int n_cmp = 0;
    int n_bad = 0;

    iterative_multiplier dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle in which the write-back appears, counting the start cycle as 0
    function automatic int exp_done(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int k;
        m = (~o[1] && b[31]) ? (~b + 32'd1) : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
`ifdef MUL_EARLY_EXIT_EN
        return ((k + 1 < 32) ? k + 1 : 32) + 2;
`else
        return 34;
`endif
    endfunction

    // Launch one op in the current cycle and watch every cycle through done+1.
    // inj > 0 pulses a second start (with other operands) in that cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] res, input int inj);
        int dn;
        dn = exp_done(o, b);
        op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
        for (int c = 1; c <= dn + 1; c++) begin
            tick();
            start = (c == inj);
            if (c == inj) begin
                op = 2'b00; rs1_data = 32'd11; rs2_data = 32'd13; rd_addr = 5'd9;
            end
            chk({tag, " busy"}, {31'd0, busy}, {31'd0, c <= dn});
            chk({tag, " wr_ena"}, {31'd0, wr_ena}, {31'd0, (c == dn) && (rd != 5'd0)});
            if (c >= dn) begin
                chk({tag, " wr_addr"}, {27'd0, wr_addr}, {27'd0, rd});
                chk({tag, " wr_data"}, wr_data, res);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00;
        rs1_data = '0; rs2_data = '0; rd_addr = '0;
        tick();
        tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset wr_ena", {31'd0, wr_ena}, 32'd0);
        chk("reset wr_addr", {27'd0, wr_addr}, 32'd0);
        chk("reset wr_data", wr_data, 32'd0);
        rst = 1'b0;
        tick();

        run_op("mul 7x6", 2'b00, 32'd7, 32'd6, 5'd5, 32'd42, 0);
        run_op("mul -3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 5'd1, 32'hFFFF_FFF1, 0);
        run_op("mulh min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 0);
        run_op("mulhu ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 0);
        run_op("mulhsu ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 0);
        run_op("mulh neg", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'hFFFF_FFFF, 0);
        run_op("mul rd0", 2'b00, 32'd9, 32'd9, 5'd0, 32'd81, 0);
        run_op("busy start", 2'b00, 32'd3, 32'h8000_0001, 5'd8, 32'h8000_0003, 5);
        run_op("back2back", 2'b11, 32'd100, 32'd200, 5'd10, 32'd0, 0);
        run_op("done start", 2'b00, 32'd12, 32'd12, 5'd11, 32'd144, exp_done(2'b00, 32'd12));
        run_op("mul 5x0", 2'b00, 32'd5, 32'd0, 5'd12, 32'd0, 0);
        run_op("mul 5x6", 2'b00, 32'd5, 32'd6, 5'd13, 32'd30, 0);

        // Abort with reset in cycle 10 of an operation
        op = 2'b00; rs1_data = 32'd17; rs2_data = 32'h4000_0000;
        rd_addr = 5'd14; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = 1'b0;
            rst = (c == 10);
            if (c < 11 && c < exp_done(2'b00, 32'h4000_0000))
                chk("abort busy", {31'd0, busy}, 32'd1);
            if (c >= 11)
                chk("abort idle", {31'd0, busy}, 32'd0);
            chk("abort wr_ena", {31'd0, wr_ena}, 32'd0);
        end
        rst = 1'b0;
        tick();
        run_op("mul 2x3", 2'b00, 32'd2, 32'd3, 5'd15, 32'd6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
